// File: rtl/main_mem_resp_pkg.sv
// Shared types and helpers for the main-memory TL-UL responder.
package main_mem_resp_pkg;

    localparam logic [2:0] OpPutFullData    = 3'h0;
    localparam logic [2:0] OpPutPartialData = 3'h1;
    localparam logic [2:0] OpGet            = 3'h4;
    localparam logic [2:0] OpAccessAck      = 3'h0;
    localparam logic [2:0] OpAccessAckData  = 3'h1;

    // Data returned for a Get that was rejected by the request checks.
    localparam logic [31:0] ErrData = 32'hFFFF_FFFF;

    // One slot of the fixed-latency pipeline that tracks each accepted request.
    typedef struct packed {
        logic                         valid;
        logic                         is_get;
        logic                         error;
        logic [tlul_pkg::TL_AIW-1:0]  source;
        logic [tlul_pkg::TL_SZW-1:0]  size;
    } pipe_entry_t;

    // One queued D-channel response.
    typedef struct packed {
        logic                         is_get;
        logic                         error;
        logic [tlul_pkg::TL_AIW-1:0]  source;
        logic [tlul_pkg::TL_SZW-1:0]  size;
        logic [31:0]                  data;
    } rsp_entry_t;

    // Byte lanes a PutFullData of the given size must enable at the given word offset.
    function automatic logic [3:0] full_mask(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] m;
        m = '0;
        case (size)
            2'd0:    m = 4'b0001 << offset;
            2'd1:    m = offset[1] ? 4'b1100 : 4'b0011;
            2'd2:    m = 4'b1111;
            default: m = 4'b0000;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/tlul_pkg.sv
// TileLink-UL channel structs and the response-integrity generator shared by TL-UL endpoints.
package tlul_pkg;

    localparam int TL_AW  = 32;
    localparam int TL_DW  = 32;
    localparam int TL_AIW = 8;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;

    typedef struct packed {
        logic [6:0] cmd_intg;
        logic [6:0] data_intg;
    } tl_a_user_t;

    typedef struct packed {
        logic [6:0] rsp_intg;
        logic [6:0] data_intg;
    } tl_d_user_t;

    typedef struct packed {
        logic              a_valid;
        logic [2:0]        a_opcode;
        logic [2:0]        a_param;
        logic [TL_SZW-1:0] a_size;
        logic [TL_AIW-1:0] a_source;
        logic [TL_AW-1:0]  a_address;
        logic [TL_DBW-1:0] a_mask;
        logic [TL_DW-1:0]  a_data;
        tl_a_user_t        a_user;
        logic              d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic              d_valid;
        logic [2:0]        d_opcode;
        logic [2:0]        d_param;
        logic [TL_SZW-1:0] d_size;
        logic [TL_AIW-1:0] d_source;
        logic [0:0]        d_sink;
        logic [TL_DW-1:0]  d_data;
        tl_d_user_t        d_user;
        logic              d_error;
        logic              a_ready;
    } tl_d2h_t;

    // Hamming code over 57 bits plus an overall parity bit in the top position.
    function automatic logic [6:0] intg_code(input logic [56:0] d);
        logic [6:0] c;
        c = '0;
        for (int j = 0; j < 57; j++) begin
            for (int i = 0; i < 6; i++) begin
                if ((((j + 1) >> i) & 1) != 0) begin
                    c[i] = c[i] ^ d[j];
                end
            end
        end
        c[6] = ^{d, c[5:0]};
        return c;
    endfunction

    // Integrity for the D channel: one code over the response header, one over the data.
    function automatic tl_d_user_t rsp_intg_gen(input logic [2:0]        opcode,
                                                input logic [TL_SZW-1:0] size,
                                                input logic              error,
                                                input logic [TL_DW-1:0]  data);
        tl_d_user_t u;
        u.rsp_intg  = intg_code(57'({opcode, size, error}));
        u.data_intg = intg_code(57'(data));
        return u;
    endfunction

endpackage

// File: rtl/main_mem_rsp_fifo.sv
// Synchronous FIFO with first-word fall-through read of the head entry.
module main_mem_rsp_fifo #(
    parameter int  Depth   = 4,
    parameter type entry_t = logic [31:0]
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       push_i,
    input  entry_t                     wdata_i,
    input  logic                       pop_i,
    output entry_t                     rdata_o,
    output logic [$clog2(Depth+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);
    localparam int              PtrW    = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int              CntW    = $clog2(Depth + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);
    localparam logic [CntW-1:0] FullCnt = CntW'(Depth);

    entry_t          mem_q [Depth];
    logic [PtrW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic            do_push, do_pop;

    assign full_o  = (count_q == FullCnt);
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign rdata_o = mem_q[rptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    // Pointer and occupancy next state; pointers wrap explicitly so any depth works.
    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        if (do_push) wptr_d = (wptr_q == LastPtr) ? '0 : wptr_q + PtrW'(1);
        if (do_pop)  rptr_d = (rptr_q == LastPtr) ? '0 : rptr_q + PtrW'(1);
        count_d = count_q + CntW'(do_push) - CntW'(do_pop);
    end

    // Control state; reset empties the queue.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Entry storage; contents are only observed while the queue is non-empty.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/main_mem_tlul_responder.sv
// TL-UL device responder for the DMA main-memory port driving a fixed-latency memory macro.
module main_mem_tlul_responder
    import tlul_pkg::*;
    import main_mem_resp_pkg::*;
#(
    parameter int MemSize     = 1048576,
    parameter int ReadLatency = 1,
    parameter int RspDepth    = 4
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  tl_h2d_t                     tl_i,
    output tl_d2h_t                     tl_o,
    output logic                        mem_req_o,
    output logic                        mem_we_o,
    output logic [$clog2(MemSize)-3:0]  mem_addr_o,
    output logic [31:0]                 mem_wdata_o,
    output logic [3:0]                  mem_be_o,
    input  logic [31:0]                 mem_rdata_i
);
    localparam int              AW       = $clog2(MemSize);
    localparam int              CntW     = $clog2(RspDepth + 1);
    localparam logic [32:0]     MemLimit = 33'(MemSize);
    localparam logic [CntW:0]   DepthW   = RspDepth[CntW:0];

    pipe_entry_t [ReadLatency-1:0] pipe_q, pipe_d;
    pipe_entry_t                   pipe_in, pipe_out;
    rsp_entry_t                    rsp_in, rsp_head;
    logic [CntW-1:0]               inflight_q, inflight_d;
    logic [CntW-1:0]               fifo_count;
    logic [CntW:0]                 credits_used;
    logic                          fifo_full, fifo_empty;
    logic                          a_ready, accept, req_err, mem_go, is_get;
    logic                          op_bad, size_bad, align_bad, range_bad, mask_bad;
    logic                          d_valid, d_pop;
    logic                          unused_sigs;

    assign unused_sigs = ^{tl_i.a_param, tl_i.a_user, fifo_full};

    // Credits cover both the latency pipeline and the response queue, so the queue can never overflow.
    assign credits_used = {1'b0, inflight_q} + {1'b0, fifo_count};
    assign a_ready      = !rst_i && (credits_used < DepthW);
    assign accept       = tl_i.a_valid && a_ready;
    assign is_get       = (tl_i.a_opcode == OpGet);

    // Request checks; any failure turns the request into an error response with no memory access.
    always_comb begin
        op_bad    = !(tl_i.a_opcode inside {OpPutFullData, OpPutPartialData, OpGet});
        size_bad  = (tl_i.a_size > 2'd2);
        align_bad = ((tl_i.a_size == 2'd1) && tl_i.a_address[0]) ||
                    ((tl_i.a_size == 2'd2) && (tl_i.a_address[1:0] != 2'b00));
        range_bad = ({1'b0, tl_i.a_address} >= MemLimit);
        mask_bad  = (tl_i.a_opcode == OpPutFullData) &&
                    (tl_i.a_mask != full_mask(tl_i.a_size, tl_i.a_address[1:0]));
        req_err   = op_bad || size_bad || align_bad || range_bad || mask_bad;
    end

    // Memory strobe in the accept cycle; other memory outputs stay at zero when idle.
    assign mem_go      = accept && !req_err;
    assign mem_req_o   = mem_go;
    assign mem_we_o    = mem_go && !is_get;
    assign mem_addr_o  = mem_go ? tl_i.a_address[AW-1:2] : '0;
    assign mem_wdata_o = mem_go ? tl_i.a_data : '0;
    assign mem_be_o    = mem_go ? (is_get ? 4'hF : tl_i.a_mask) : 4'h0;

    // Every accepted request, errored or not, enters the pipeline to keep responses in order.
    always_comb begin
        pipe_in        = '0;
        pipe_in.valid  = accept;
        pipe_in.is_get = is_get;
        pipe_in.error  = req_err;
        pipe_in.source = tl_i.a_source;
        pipe_in.size   = tl_i.a_size;
    end

    genvar gi;
    for (gi = 0; gi < ReadLatency; gi++) begin : g_pipe
        if (gi == 0) begin : g_first
            assign pipe_d[gi] = pipe_in;
        end else begin : g_shift
            assign pipe_d[gi] = pipe_q[gi-1];
        end
    end

    assign pipe_out   = pipe_q[ReadLatency-1];
    assign inflight_d = inflight_q + CntW'(accept) - CntW'(pipe_out.valid);

    // Latency pipeline and its occupancy counter.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            pipe_q     <= '0;
            inflight_q <= '0;
        end else begin
            pipe_q     <= pipe_d;
            inflight_q <= inflight_d;
        end
    end

    // Entry leaving the pipeline becomes a response; memory data is valid exactly now.
    always_comb begin
        rsp_in        = '0;
        rsp_in.is_get = pipe_out.is_get;
        rsp_in.error  = pipe_out.error;
        rsp_in.source = pipe_out.source;
        rsp_in.size   = pipe_out.size;
        if (pipe_out.is_get) rsp_in.data = pipe_out.error ? ErrData : mem_rdata_i;
    end

    main_mem_rsp_fifo #(
        .Depth   (RspDepth),
        .entry_t (rsp_entry_t)
    ) u_rsp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (pipe_out.valid),
        .wdata_i (rsp_in),
        .pop_i   (d_pop),
        .rdata_o (rsp_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign d_valid = !rst_i && !fifo_empty;
    assign d_pop   = d_valid && tl_i.d_ready;

    // D channel driven from the queue head; everything reads zero while no response is offered.
    always_comb begin
        tl_o         = '0;
        tl_o.a_ready = a_ready;
        if (d_valid) begin
            tl_o.d_valid  = 1'b1;
            tl_o.d_opcode = rsp_head.is_get ? OpAccessAckData : OpAccessAck;
            tl_o.d_size   = rsp_head.size;
            tl_o.d_source = rsp_head.source;
            tl_o.d_data   = rsp_head.data;
            tl_o.d_error  = rsp_head.error;
            tl_o.d_user   = rsp_intg_gen(tl_o.d_opcode, rsp_head.size, rsp_head.error, rsp_head.data);
        end
    end

endmodule
